// File: rtl/gf2m_trinomial_reducer_if.sv
// Request/result bus between the product source and the GF(2^N) trinomial reducer.
// The master supplies start and the 2N-bit product; the slave returns the residue, busy and done.
interface gf2m_trinomial_reducer_if #(
  parameter int N = 233
);
  logic           start;
  logic [2*N-1:0] c;
  logic [N-1:0]   r;
  logic           busy;
  logic           done;

  modport master (output start, c, input r, busy, done);
  modport slave  (input start, c, output r, busy, done);
endinterface

// File: rtl/gf2m_trinomial_reducer.sv
// Bit-serial reduction of a 2N-bit carry-less product modulo x^N + x^K + 1.
// Optional build macro GF2M_REDUCER_EARLY_EXIT_EN finishes as soon as no bits remain at or above N.
//
// state | meaning
// IDLE  | waiting for start; product latched on the accepting edge
// RUN   | one fold step per edge, idx descending from 2N-1 down to N
// DONE  | residue valid, done pulses for this single cycle
module gf2m_trinomial_reducer #(
  parameter int N = 233,
  parameter int K = 74
) (
  input  logic                     clk,
  input  logic                     rst,
  gf2m_trinomial_reducer_if.slave  bus
);

  localparam int W  = 2 * N;
  localparam int IW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [N-1:0]    r_q, r_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [W-1:0]    stepped;
  logic [IW-1:0]   tap_mid;
  logic [IW-1:0]   tap_lo;

  // x^idx = x^(idx-N) * (x^K + 1); both taps lie strictly below idx while idx >= N.
  always_comb begin
    tap_mid = idx_q - IW'(N - K);
    tap_lo  = idx_q - IW'(N);
    stepped = acc_q;
    if (acc_q[idx_q]) begin
      stepped[idx_q]   = 1'b0;
      stepped[tap_mid] = ~acc_q[tap_mid];
      stepped[tap_lo]  = ~acc_q[tap_lo];
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    r_d     = r_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d   = bus.c;
          idx_d   = IW'(W - 1);
          state_d = RUN;
        end
      end
      RUN: begin
`ifdef GF2M_REDUCER_EARLY_EXIT_EN
        if (acc_q[W-1:N] == '0) begin
          r_d     = acc_q[N-1:0];
          state_d = DONE;
        end else
`endif
        begin
          acc_d = stepped;
          idx_d = idx_q - IW'(1);
          if (idx_q == IW'(N)) begin
            r_d     = stepped[N-1:0];
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.r    = r_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_gf2m_trinomial_reducer.sv
// Directed bench for gf2m_trinomial_reducer (B-233 trinomial x^233 + x^74 + 1).
// Works in both builds; define GF2M_REDUCER_EARLY_EXIT_EN to check the early-exit latency.
module tb_gf2m_trinomial_reducer;
  localparam int N = 233;
  localparam int K = 74;
  localparam int W = 2 * N;

  logic clk = 1'b0;
  logic rst;

  gf2m_trinomial_reducer_if #(.N(N)) bus ();
  gf2m_trinomial_reducer #(.N(N), .K(K)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // One request; optionally fires a competing start mid-RUN that must be ignored.
  task automatic run(input string tag, input logic [W-1:0] cv, input logic [N-1:0] exp_r,
                     input bit poke, input logic [W-1:0] poke_c);
    int lat;
    int bcyc;
    int dones;
    @(negedge clk);
    bus.c     = cv;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.c     = ~cv;
    lat   = -1;
    bcyc  = 0;
    dones = 0;
    for (int k = 1; k <= N + 8; k++) begin
      if (poke && k == 50) begin
        bus.start = 1'b1;
        bus.c     = poke_c;
      end
      if (poke && k == 51) bus.start = 1'b0;
      if (bus.busy) bcyc++;
      if (bus.done) begin
        dones++;
        if (lat < 0) lat = k;
      end
      @(posedge clk);
      #1;
    end
    chk({tag, ".r"}, bus.r, exp_r);
    chk({tag, ".done_pulses"}, N'(dones), N'(1));
`ifdef GF2M_REDUCER_EARLY_EXIT_EN
    if (cv[W-1:N] == '0) begin
      chk({tag, ".latency"}, N'(lat), N'(2));
      chk({tag, ".busy_cycles"}, N'(bcyc), N'(2));
    end else begin
      chk({tag, ".latency_in_range"}, N'(lat >= 2 && lat <= N + 1), N'(1));
      chk({tag, ".busy_cycles"}, N'(bcyc), N'(lat));
    end
`else
    chk({tag, ".latency"}, N'(lat), N'(N + 1));
    chk({tag, ".busy_cycles"}, N'(bcyc), N'(N + 1));
`endif
  endtask

  initial begin
    logic [W-1:0] cv;
    logic [W-1:0] pc;
    logic [N-1:0] er;
    int dones;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.c     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.r", bus.r, '0);
    chk("reset.busy", N'(bus.busy), N'(0));
    chk("reset.done", N'(bus.done), N'(0));
    @(negedge clk);
    rst = 1'b0;

    cv = '0;
    er = '0;
    run("zero", cv, er, 1'b0, '0);

    cv = '0; cv[233] = 1'b1;
    er = '0; er[74] = 1'b1; er[0] = 1'b1;
    run("x233", cv, er, 1'b0, '0);

    cv = '0; cv[464] = 1'b1;
    er = '0; er[231] = 1'b1; er[146] = 1'b1; er[72] = 1'b1;
    run("x464", cv, er, 1'b0, '0);

    cv = '0; cv[465] = 1'b1;
    er = '0; er[232] = 1'b1; er[147] = 1'b1; er[73] = 1'b1;
    run("x465_top_bit", cv, er, 1'b0, '0);

    cv = '0; cv[15:0] = 16'h1234;
    er = '0; er[15:0] = 16'h1234;
    run("low_1234", cv, er, 1'b0, '0);

    cv = '0; cv[233] = 1'b1; cv[0] = 1'b1;
    er = '0; er[74] = 1'b1;
    run("x233_plus_1", cv, er, 1'b0, '0);

    cv = '0; cv[N-1:0] = '1;
    er = '1;
    run("low_all_ones", cv, er, 1'b0, '0);

    cv = '0; cv[465] = 1'b1; cv[464] = 1'b1; cv[233] = 1'b1;
    er = '0;
    er[232] = 1'b1; er[147] = 1'b1; er[73] = 1'b1;
    er[231] = 1'b1; er[146] = 1'b1; er[72] = 1'b1;
    er[74]  = 1'b1; er[0]   = 1'b1;
    run("mixed", cv, er, 1'b0, '0);

    cv = '0; cv[464] = 1'b1;
    pc = '0; pc[233] = 1'b1;
    er = '0; er[231] = 1'b1; er[146] = 1'b1; er[72] = 1'b1;
    run("start_in_run", cv, er, 1'b1, pc);

    // Abort a request 100 edges in; r must clear from its prior nonzero value.
    cv = '0; cv[465] = 1'b1;
    @(negedge clk);
    bus.c     = cv;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (99) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort.r", bus.r, '0);
    chk("abort.busy", N'(bus.busy), N'(0));
    chk("abort.done", N'(bus.done), N'(0));
    @(negedge clk);
    rst   = 1'b0;
    dones = 0;
    for (int k = 0; k < N + 8; k++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) dones++;
    end
    chk("abort.no_late_activity", N'(dones), N'(0));

    cv = '0; cv[233] = 1'b1;
    er = '0; er[74] = 1'b1; er[0] = 1'b1;
    run("after_abort", cv, er, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
